// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO: a frame reaches m_axis only after a good tlast
// commits it; bad frames and frames that overflow the store are rewound and counted.
module axis_frame_fifo #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              s_axis_tready,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              frame_drop,
  output logic [15:0]       drop_count,
  output logic [ADDR_W:0]   frames_stored
);

  typedef enum logic [1:0] {IDLE, FRAME, DROP} wr_state_t;

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [8:0]      mem [DEPTH];
  wr_state_t       state, state_next;
  logic [ADDR_W:0] wr_ptr, wr_ptr_next;
  logic [ADDR_W:0] wr_commit, commit_next;
  logic [ADDR_W:0] rd_ptr, fetch_ptr;
  logic            beat, full, wr_en, drop, commit;
  logic            fetch, load, pop, pop_last;
  logic [8:0]      rd_data;
  logic            rd_valid;

  assign beat = s_axis_tvalid && s_axis_tready;
  assign full = (wr_ptr - rd_ptr) == FULL_LVL;

  // rd_ptr frees space only when a byte leaves m_axis; fetch_ptr runs ahead of it by
  // the bytes sitting in the read stage and the output register.
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign pop_last = pop && m_axis_tlast;
  assign load     = rd_valid && (!m_axis_tvalid || m_axis_tready);
  assign fetch    = (fetch_ptr != wr_commit) && (!rd_valid || load);

  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    commit_next = wr_commit;
    wr_en       = 1'b0;
    drop        = 1'b0;
    commit      = 1'b0;
    if (beat) begin
      case (state)
        IDLE, FRAME: begin
          if (full) begin
            wr_ptr_next = wr_commit;
            drop        = 1'b1;
            state_next  = s_axis_tlast ? IDLE : DROP;
          end else begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr + PTR_ONE;
            if (s_axis_tlast) begin
              state_next = IDLE;
              if (s_axis_tuser) begin
                wr_ptr_next = wr_commit;
                drop        = 1'b1;
              end else begin
                commit_next = wr_ptr + PTR_ONE;
                commit      = 1'b1;
              end
            end else begin
              state_next = FRAME;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The write and read addresses can never coincide: reads stay below wr_commit and
  // writes are refused once the window from rd_ptr spans the whole store.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (fetch) rd_data <= mem[fetch_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      rd_ptr        <= '0;
      fetch_ptr     <= '0;
      rd_valid      <= 1'b0;
      frame_drop    <= 1'b0;
      drop_count    <= '0;
      frames_stored <= '0;
    end else begin
      state         <= state_next;
      s_axis_tready <= 1'b1;
      wr_ptr        <= wr_ptr_next;
      wr_commit     <= commit_next;
      frame_drop    <= drop;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (fetch) begin
        fetch_ptr <= fetch_ptr + PTR_ONE;
        rd_valid  <= 1'b1;
      end else if (load) begin
        rd_valid  <= 1'b0;
      end
      case ({commit, pop_last})
        2'b10:   frames_stored <= frames_stored + PTR_ONE;
        2'b01:   frames_stored <= frames_stored - PTR_ONE;
        default: frames_stored <= frames_stored;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= rd_data[8];
      m_axis_tdata  <= rd_data[7:0];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo: a DEPTH=16 and a DEPTH=256 instance share the
// ingress stimulus; each scenario observes one of them through the o_* mux.
module tb_axis_frame_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser, m_ready;

  logic        sm_sready, sm_valid, sm_last, sm_drop;
  logic [7:0]  sm_data;
  logic [15:0] sm_dcount;
  logic [4:0]  sm_fstored;
  logic        lg_sready, lg_valid, lg_last, lg_drop;
  logic [7:0]  lg_data;
  logic [15:0] lg_dcount;
  logic [8:0]  lg_fstored;

  logic        sel;
  bit          tx_done;
  logic        o_valid, o_last, o_drop;
  logic [7:0]  o_data;
  logic [15:0] o_dcount;
  logic [8:0]  o_fstored;

  int checks = 0;
  int failures = 0;

  logic [8:0] got_q[$];
  int         drop_pulses = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;

  always #5 clk = ~clk;

  axis_frame_fifo #(.DEPTH(16)) dut_small (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(sm_sready),
    .m_axis_tdata(sm_data), .m_axis_tvalid(sm_valid), .m_axis_tlast(sm_last),
    .m_axis_tready(m_ready), .frame_drop(sm_drop), .drop_count(sm_dcount),
    .frames_stored(sm_fstored)
  );

  axis_frame_fifo #(.DEPTH(256)) dut_large (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(lg_sready),
    .m_axis_tdata(lg_data), .m_axis_tvalid(lg_valid), .m_axis_tlast(lg_last),
    .m_axis_tready(m_ready), .frame_drop(lg_drop), .drop_count(lg_dcount),
    .frames_stored(lg_fstored)
  );

  always_comb begin
    o_valid   = sel ? lg_valid : sm_valid;
    o_last    = sel ? lg_last : sm_last;
    o_data    = sel ? lg_data : sm_data;
    o_drop    = sel ? lg_drop : sm_drop;
    o_dcount  = sel ? lg_dcount : sm_dcount;
    o_fstored = sel ? lg_fstored : {4'b0000, sm_fstored};
  end

  // Records every egress handshake, drop pulse and any change of a stalled output.
  always @(negedge clk) begin
    if (o_valid && m_ready) got_q.push_back({o_last, o_data});
    if (o_drop) drop_pulses <= drop_pulses + 1;
    if (prev_stall && (!o_valid || {o_last, o_data} != prev_beat)) stall_err <= stall_err + 1;
    prev_stall <= o_valid && !m_ready;
    prev_beat  <= {o_last, o_data};
  end

  task automatic do_reset();
    resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] first, input int len, input logic bad);
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = first + 8'(i);
      s_tlast  = (i == len - 1);
      s_tuser  = bad && (i == len - 1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_tvalid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({sm_sready, sm_valid, sm_last, sm_data, sm_drop, sm_dcount, sm_fstored} !== '0) begin
      failures++;
      $display("FAIL reset_small outputs=%h want=0", {sm_sready, sm_valid, sm_last, sm_data, sm_drop, sm_dcount, sm_fstored});
    end
    checks++;
    if ({lg_sready, lg_valid, lg_last, lg_data, lg_drop, lg_dcount, lg_fstored} !== '0) begin
      failures++;
      $display("FAIL reset_large outputs=%h want=0", {lg_sready, lg_valid, lg_last, lg_data, lg_drop, lg_dcount, lg_fstored});
    end
    @(negedge clk); resetn = 1'b1; #1;
    checks++;
    if (sm_sready !== 1'b0) begin
      failures++; $display("FAIL tready_before_edge got=%b want=0", sm_sready);
    end
    @(posedge clk); #1;
    checks++;
    if (sm_sready !== 1'b1 || lg_sready !== 1'b1) begin
      failures++; $display("FAIL tready_first_edge got=%b%b want=11", sm_sready, lg_sready);
    end
  endtask

  task automatic test_single_frame();
    sel = 1'b1; do_reset(); m_ready = 1'b1;
    send_frame(8'h00, 64, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_fstored !== 9'd1) begin
      failures++; $display("FAIL commit_edge valid=%b stored=%0d want valid=0 stored=1", o_valid, o_fstored);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL latency_edge1 valid=%b want=0", o_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'(i) || o_last !== (i == 63)) begin
        failures++;
        $display("FAIL stream_byte%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, o_valid, o_data, o_last, 8'(i), (i == 63));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (o_valid !== 1'b0 || o_fstored !== 9'd0) begin
      failures++; $display("FAIL stream_end valid=%b stored=%0d want 0 0", o_valid, o_fstored);
    end
  endtask

  task automatic test_drop_bad();
    logic [8:0] exp_q[$];
    int n0, d0;
    sel = 1'b1; do_reset(); m_ready = 1'b1;
    n0 = got_q.size(); d0 = drop_pulses;
    for (int i = 0; i < 10; i++) exp_q.push_back({i == 9, 8'h10 + 8'(i)});
    for (int i = 0; i < 5; i++)  exp_q.push_back({i == 4, 8'h40 + 8'(i)});
    send_frame(8'h10, 10, 1'b0);
    send_frame(8'h80, 20, 1'b1);
    send_frame(8'h40, 5, 1'b0);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (got_q.size() - n0 != exp_q.size()) begin
      failures++; $display("FAIL bad_frame_count got=%0d want=%0d", got_q.size() - n0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[n0 + i] !== exp_q[i]) begin
          failures++; $display("FAIL bad_frame_byte%0d got=%h want=%h", i, got_q[n0 + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (drop_pulses - d0 != 1 || o_dcount !== 16'd1) begin
      failures++; $display("FAIL bad_frame_drops pulses=%0d count=%0d want 1 1", drop_pulses - d0, o_dcount);
    end
  endtask

  task automatic test_full_drop();
    int n0;
    sel = 1'b0; do_reset(); m_ready = 1'b0;
    send_frame(8'hA0, 8, 1'b0);
    for (int i = 0; i < 12; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'hB0 + 8'(i); s_tlast = (i == 11); s_tuser = 1'b0;
      @(posedge clk); #1;
      if (i == 7) begin
        checks++;
        if (o_drop !== 1'b0 || o_dcount !== 16'd0) begin
          failures++; $display("FAIL full_byte8 drop=%b count=%0d want 0 0", o_drop, o_dcount);
        end
      end
      if (i == 8) begin
        checks++;
        if (o_drop !== 1'b1) begin
          failures++; $display("FAIL full_byte9 drop=%b want=1", o_drop);
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++;
    if (o_dcount !== 16'd1 || o_drop !== 1'b0 || o_fstored !== 9'd1) begin
      failures++; $display("FAIL full_after count=%0d drop=%b stored=%0d want 1 0 1", o_dcount, o_drop, o_fstored);
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hA0 || o_last !== 1'b0) begin
      failures++; $display("FAIL full_stall v=%b d=%h l=%b want 1 a0 0", o_valid, o_data, o_last);
    end
    n0 = got_q.size(); m_ready = 1'b1;
    repeat (15) @(posedge clk); #1;
    checks++;
    if (got_q.size() - n0 != 8) begin
      failures++; $display("FAIL full_out_count got=%0d want=8", got_q.size() - n0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[n0 + i] !== {i == 7, 8'hA0 + 8'(i)}) begin
          failures++; $display("FAIL full_out_byte%0d got=%h want=%h", i, got_q[n0 + i], {i == 7, 8'hA0 + 8'(i)});
        end
      end
    end
  endtask

  task automatic test_oversize();
    int n0, d0;
    sel = 1'b0; do_reset(); m_ready = 1'b1;
    n0 = got_q.size(); d0 = drop_pulses;
    send_frame(8'h60, 17, 1'b0);
    checks++;
    if (o_dcount !== 16'd1 || o_fstored !== 9'd0) begin
      failures++; $display("FAIL oversize17 count=%0d stored=%0d want 1 0", o_dcount, o_fstored);
    end
    send_frame(8'h70, 20, 1'b0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (drop_pulses - d0 != 2 || o_dcount !== 16'd2 || got_q.size() != n0) begin
      failures++;
      $display("FAIL oversize20 pulses=%0d count=%0d out=%0d want 2 2 0", drop_pulses - d0, o_dcount, got_q.size() - n0);
    end
    send_frame(8'hC5, 1, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (got_q.size() - n0 != 1 || got_q[got_q.size() - 1] !== 9'h1C5) begin
      failures++; $display("FAIL single_byte_frame out=%0d last=%h want 1 1c5", got_q.size() - n0, got_q[got_q.size() - 1]);
    end
  endtask

  task automatic test_reset_midframe();
    int n0, d0;
    sel = 1'b1; do_reset(); m_ready = 1'b0;
    d0 = drop_pulses;
    send_frame(8'h20, 4, 1'b0);
    send_frame(8'h30, 4, 1'b0);
    for (int i = 0; i < 15; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'h90 + 8'(i); s_tlast = 1'b0; s_tuser = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (o_fstored !== 9'd2 || o_valid !== 1'b1) begin
      failures++; $display("FAIL midframe_before stored=%0d valid=%b want 2 1", o_fstored, o_valid);
    end
    resetn = 1'b0; s_tvalid = 1'b0;
    #1;
    checks++;
    if ({lg_sready, lg_valid, lg_last, lg_data, lg_drop, lg_dcount, lg_fstored} !== '0) begin
      failures++;
      $display("FAIL midframe_in_reset outputs=%h want=0", {lg_sready, lg_valid, lg_last, lg_data, lg_drop, lg_dcount, lg_fstored});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1; n0 = got_q.size();
    repeat (5) @(posedge clk); #1;
    checks++;
    if (got_q.size() != n0 || drop_pulses != d0 || o_fstored !== 9'd0 || o_dcount !== 16'd0) begin
      failures++;
      $display("FAIL midframe_after out=%0d pulses=%0d stored=%0d count=%0d want all 0", got_q.size() - n0, drop_pulses - d0, o_fstored, o_dcount);
    end
    send_frame(8'h55, 3, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (got_q.size() - n0 != 3) begin
      failures++; $display("FAIL midframe_new_count got=%0d want=3", got_q.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[n0 + i] !== {i == 2, 8'h55 + 8'(i)}) begin
          failures++; $display("FAIL midframe_new_byte%0d got=%h want=%h", i, got_q[n0 + i], {i == 2, 8'h55 + 8'(i)});
        end
      end
    end
  endtask

  // Idle gaps of twice the frame length keep the backlog far below 256 bytes, so only
  // tuser frames are expected to drop.
  task automatic test_random();
    logic [8:0] exp_q[$];
    int n0, d0, s0, nbad, got_n, len;
    logic [7:0] base;
    logic bad;
    sel = 1'b1; do_reset();
    n0 = got_q.size(); d0 = drop_pulses; s0 = stall_err; nbad = 0; tx_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 200; f++) begin
          len  = int'($urandom_range(1, 60));
          bad  = ($urandom_range(0, 7) == 0);
          base = 8'($urandom);
          if (bad) nbad++;
          else for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, base + 8'(i)});
          send_frame(base, len, bad);
          repeat (2 * len) @(posedge clk);
          #1;
        end
        tx_done = 1'b1;
      end
      begin
        for (int c = 0; c < 60000 && !tx_done; c++) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    m_ready = 1'b1;
    for (int c = 0; c < 2000 && (got_q.size() - n0) < exp_q.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    got_n = got_q.size() - n0;
    checks++;
    if (got_n != exp_q.size()) begin
      failures++; $display("FAIL random_count got=%0d want=%0d", got_n, exp_q.size());
    end
    for (int i = 0; i < got_n && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[n0 + i] !== exp_q[i]) begin
        failures++; $display("FAIL random_byte%0d got=%h want=%h", i, got_q[n0 + i], exp_q[i]);
      end
    end
    checks++;
    if (o_dcount !== 16'(nbad) || drop_pulses - d0 != nbad) begin
      failures++; $display("FAIL random_drops count=%0d pulses=%0d want=%0d", o_dcount, drop_pulses - d0, nbad);
    end
    checks++;
    if (stall_err - s0 != 0) begin
      failures++; $display("FAIL random_stall_stable changes=%0d want=0", stall_err - s0);
    end
    checks++;
    if (o_fstored !== 9'd0 || o_valid !== 1'b0) begin
      failures++; $display("FAIL random_drained stored=%0d valid=%b want 0 0", o_fstored, o_valid);
    end
  endtask

  initial begin
    resetn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_ready = 1'b0; sel = 1'b0; tx_done = 1'b0;
    test_reset();
    test_single_frame();
    test_drop_bad();
    test_full_drop();
    test_oversize();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
